branch_resolve_unit: RTL and testbench

- Execute-stage neighbour directly downstream of the scalar ALU.
- Pairs each branch's metadata with the ALU's registered result one cycle later, then decides taken/not-taken from the result and zero flag.
- Computes the target and detects mispredicts against the front-end prediction.
- On a mispredict it drives a valid/ready redirect to fetch and a bounded flush/stall sequence to the pipeline.

---
 rtl/branch_resolve_unit_if.sv | 23 ++
 rtl/branch_resolve_unit.sv | 206 ++++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_if.sv
// Redirect channel from the branch resolve unit to fetch.
// Handshake: valid/ready. Once redir_valid_o rises, redir_valid_o and redir_pc_o
// hold steady until a cycle where redir_ready_i is also high; the transfer
// completes on that cycle's rising edge.
interface branch_resolve_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  redir_valid_o;
  logic [DATA_WIDTH-1:0] redir_pc_o;
  logic                  redir_ready_i;

  modport master (
    output redir_valid_o,
    output redir_pc_o,
    input  redir_ready_i
  );

  modport slave (
    input  redir_valid_o,
    input  redir_pc_o,
    output redir_ready_i
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver: pairs branch metadata with the registered ALU result,
// resolves taken/mispredict, and redirects fetch. Optional perf counters: BRU_PERF_CNT_EN.
module branch_resolve_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid_i,
  input  logic                  issue_is_branch_i,
  input  logic [3:0]            issue_op_i,
  input  logic [DATA_WIDTH-1:0] issue_pc_i,
  input  logic [DATA_WIDTH-1:0] issue_imm_i,
  input  logic                  issue_pred_taken_i,
  input  logic [DATA_WIDTH-1:0] alu_res_i,
  input  logic                  alu_zero_i,
  output logic                  stall_o,
  output logic                  flush_o,
  branch_resolve_unit_if.master redir,
  output logic                  resolve_valid_o,
  output logic                  resolve_taken_o,
  output logic                  resolve_mispred_o,
  output logic [DATA_WIDTH-1:0] resolve_pc_o,
  output logic [31:0]           perf_branches_o,
  output logic [31:0]           perf_mispred_o,
  output logic [1:0]            dbg_state_o
);

  localparam logic [3:0] OP_BEQ  = 4'b1010;
  localparam logic [3:0] OP_BNE  = 4'b1011;
  localparam logic [3:0] OP_BLT  = 4'b1100;
  localparam logic [3:0] OP_BGE  = 4'b1101;
  localparam logic [3:0] OP_BLTU = 4'b1110;
  localparam logic [3:0] OP_BGEU = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  s0_valid_q, s0_valid_d;
  logic [3:0]            s0_op_q, s0_op_d;
  logic [DATA_WIDTH-1:0] s0_pc_q, s0_pc_d;
  logic [DATA_WIDTH-1:0] s0_imm_q, s0_imm_d;
  logic                  s0_pred_q, s0_pred_d;
  logic                  s1_valid_q, s1_valid_d;
  logic                  s1_taken_q, s1_taken_d;
  logic                  s1_mispred_q, s1_mispred_d;
  logic [DATA_WIDTH-1:0] s1_pc_q, s1_pc_d;
  logic [DATA_WIDTH-1:0] s1_redir_pc_q, s1_redir_pc_d;

  logic                  accept;
  logic                  resolve_now;
  logic                  is_branch_op;
  logic                  taken;
  logic                  mispred;
  logic [DATA_WIDTH-1:0] target_pc;
  logic [DATA_WIDTH-1:0] fall_pc;
  logic                  unused_alu_bits;

  assign unused_alu_bits = ^alu_res_i[DATA_WIDTH-1:1];

  // Outcome of the branch sitting in S0, using this cycle's ALU outputs.
  always_comb begin
    taken = 1'b0;
    case (s0_op_q)
      OP_BEQ:           taken = alu_zero_i;
      OP_BNE:           taken = !alu_zero_i;
      OP_BLT, OP_BLTU:  taken = alu_res_i[0];
      OP_BGE, OP_BGEU:  taken = !alu_res_i[0];
      default:          taken = 1'b0;
    endcase
    is_branch_op = s0_op_q inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
    mispred      = is_branch_op && (taken != s0_pred_q);
    target_pc    = s0_pc_q + s0_imm_q;
    fall_pc      = s0_pc_q + DATA_WIDTH'(4);
  end

  always_comb begin
    accept      = issue_valid_i && issue_is_branch_i && (state_q == ST_IDLE);
    // S0 entries arriving while a redirect/flush is in progress are wrong-path.
    resolve_now = s0_valid_q && (state_q == ST_IDLE);

    s0_valid_d    = accept;
    s0_op_d       = s0_op_q;
    s0_pc_d       = s0_pc_q;
    s0_imm_d      = s0_imm_q;
    s0_pred_d     = s0_pred_q;
    s1_valid_d    = resolve_now;
    s1_taken_d    = s1_taken_q;
    s1_mispred_d  = s1_mispred_q;
    s1_pc_d       = s1_pc_q;
    s1_redir_pc_d = s1_redir_pc_q;
    state_d       = state_q;
    cnt_d         = cnt_q;

    if (accept) begin
      s0_op_d   = issue_op_i;
      s0_pc_d   = issue_pc_i;
      s0_imm_d  = issue_imm_i;
      s0_pred_d = issue_pred_taken_i;
    end

    if (resolve_now) begin
      s1_taken_d    = taken;
      s1_mispred_d  = mispred;
      s1_pc_d       = s0_pc_q;
      s1_redir_pc_d = taken ? target_pc : fall_pc;
    end

    // REDIRECT is entered together with the resolve pulse of the mispredicting branch.
    case (state_q)
      ST_IDLE: begin
        if (resolve_now && mispred) state_d = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        if (redir.redir_ready_i) begin
          cnt_d   = 4'(FLUSH_CYCLES);
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      s0_valid_q    <= 1'b0;
      s0_op_q       <= '0;
      s0_pc_q       <= '0;
      s0_imm_q      <= '0;
      s0_pred_q     <= 1'b0;
      s1_valid_q    <= 1'b0;
      s1_taken_q    <= 1'b0;
      s1_mispred_q  <= 1'b0;
      s1_pc_q       <= '0;
      s1_redir_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      s0_valid_q    <= s0_valid_d;
      s0_op_q       <= s0_op_d;
      s0_pc_q       <= s0_pc_d;
      s0_imm_q      <= s0_imm_d;
      s0_pred_q     <= s0_pred_d;
      s1_valid_q    <= s1_valid_d;
      s1_taken_q    <= s1_taken_d;
      s1_mispred_q  <= s1_mispred_d;
      s1_pc_q       <= s1_pc_d;
      s1_redir_pc_q <= s1_redir_pc_d;
    end
  end

  assign stall_o             = (state_q != ST_IDLE);
  assign flush_o             = (state_q != ST_IDLE);
  assign redir.redir_valid_o = (state_q == ST_REDIRECT);
  assign redir.redir_pc_o    = s1_redir_pc_q;
  assign resolve_valid_o     = s1_valid_q;
  assign resolve_taken_o     = s1_taken_q;
  assign resolve_mispred_o   = s1_mispred_q;
  assign resolve_pc_o        = s1_pc_q;
  assign dbg_state_o         = state_q;

`ifdef BRU_PERF_CNT_EN
  logic [31:0] perf_br_q, perf_br_d;
  logic [31:0] perf_mp_q, perf_mp_d;

  // Saturating event counters driven by the resolve pulse.
  always_comb begin
    perf_br_d = perf_br_q;
    perf_mp_d = perf_mp_q;
    if (s1_valid_q && (perf_br_q != 32'hFFFF_FFFF)) perf_br_d = perf_br_q + 32'd1;
    if (s1_valid_q && s1_mispred_q && (perf_mp_q != 32'hFFFF_FFFF)) perf_mp_d = perf_mp_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_br_q <= '0;
      perf_mp_q <= '0;
    end else begin
      perf_br_q <= perf_br_d;
      perf_mp_q <= perf_mp_d;
    end
  end

  assign perf_branches_o = perf_br_q;
  assign perf_mispred_o  = perf_mp_q;
`else
  assign perf_branches_o = 32'd0;
  assign perf_mispred_o  = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: vector table plus hand-written
// sequences for redirect hold, squash, back-to-back issue and mid-redirect reset.
module tb_branch_resolve_unit;
  localparam int DW = 32;
  localparam int FC = 2;
`ifdef BRU_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          issue_valid_i;
  logic          issue_is_branch_i;
  logic [3:0]    issue_op_i;
  logic [DW-1:0] issue_pc_i;
  logic [DW-1:0] issue_imm_i;
  logic          issue_pred_taken_i;
  logic [DW-1:0] alu_res_i;
  logic          alu_zero_i;
  logic          stall_o;
  logic          flush_o;
  logic          resolve_valid_o;
  logic          resolve_taken_o;
  logic          resolve_mispred_o;
  logic [DW-1:0] resolve_pc_o;
  logic [31:0]   perf_branches_o;
  logic [31:0]   perf_mispred_o;
  logic [1:0]    dbg_state_o;

  branch_resolve_unit_if #(.DATA_WIDTH(DW)) redir_if ();

  branch_resolve_unit #(.DATA_WIDTH(DW), .FLUSH_CYCLES(FC)) dut (
    .clk                (clk),
    .rst                (rst),
    .issue_valid_i      (issue_valid_i),
    .issue_is_branch_i  (issue_is_branch_i),
    .issue_op_i         (issue_op_i),
    .issue_pc_i         (issue_pc_i),
    .issue_imm_i        (issue_imm_i),
    .issue_pred_taken_i (issue_pred_taken_i),
    .alu_res_i          (alu_res_i),
    .alu_zero_i         (alu_zero_i),
    .stall_o            (stall_o),
    .flush_o            (flush_o),
    .redir              (redir_if),
    .resolve_valid_o    (resolve_valid_o),
    .resolve_taken_o    (resolve_taken_o),
    .resolve_mispred_o  (resolve_mispred_o),
    .resolve_pc_o       (resolve_pc_o),
    .perf_branches_o    (perf_branches_o),
    .perf_mispred_o     (perf_mispred_o),
    .dbg_state_o        (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  int checks   = 0;
  int failures = 0;
  int model_br = 0;
  int model_mp = 0;
  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic [3:0]    op;
    logic [DW-1:0] pc;
    logic [DW-1:0] imm;
    logic          pred;
    logic [DW-1:0] res;
    logic          zero;
    logic          exp_taken;
    logic          exp_mispred;
    logic [DW-1:0] exp_pc;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic chk_perf(input string name);
    chk({name, "_perf_br"}, perf_branches_o, PERF_EN ? 32'(model_br) : 32'd0);
    chk({name, "_perf_mp"}, perf_mispred_o,  PERF_EN ? 32'(model_mp) : 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    issue_valid_i = 1'b0;
    redir_if.redir_ready_i = 1'b0;
    tick();
    model_br = 0;
    model_mp = 0;
    rst = 1'b0;
  endtask

  task automatic drive_issue(input logic [3:0] op, input logic [DW-1:0] pc,
                             input logic [DW-1:0] imm, input logic pred);
    issue_valid_i      = 1'b1;
    issue_is_branch_i  = 1'b1;
    issue_op_i         = op;
    issue_pc_i         = pc;
    issue_imm_i        = imm;
    issue_pred_taken_i = pred;
  endtask

  // Wait out the flush, counting cycles with flush_o high; bounded.
  task automatic drain(input string name, input int exp_len, output int pulses);
    int n;
    n = 0;
    pulses = 0;
    while (flush_o === 1'b1 && n < 20) begin
      n++;
      if (resolve_valid_o === 1'b1) pulses++;
      tick();
    end
    chk({name, "_flush_len"}, 32'(n), 32'(exp_len));
    chk({name, "_idle_stall"}, {31'd0, stall_o}, 32'd0);
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int   pulses;
    v = vecs[i];
    drive_issue(v.op, v.pc, v.imm, v.pred);
    tick();
    issue_valid_i = 1'b0;
    alu_res_i     = v.res;
    alu_zero_i    = v.zero;
    tick();
    chk($sformatf("v%0d_rvalid", i),  {31'd0, resolve_valid_o},   32'd1);
    chk($sformatf("v%0d_taken", i),   {31'd0, resolve_taken_o},   {31'd0, v.exp_taken});
    chk($sformatf("v%0d_mispred", i), {31'd0, resolve_mispred_o}, {31'd0, v.exp_mispred});
    chk($sformatf("v%0d_rpc", i),     resolve_pc_o,               v.pc);
    chk($sformatf("v%0d_redir_pc", i), redir_if.redir_pc_o,       v.exp_pc);
    chk($sformatf("v%0d_redir_v", i), {31'd0, redir_if.redir_valid_o}, {31'd0, v.exp_mispred});
    chk($sformatf("v%0d_stall", i),   {31'd0, stall_o},           {31'd0, v.exp_mispred});
    model_br++;
    if (v.exp_mispred) model_mp++;
    if (v.exp_mispred) begin
      redir_if.redir_ready_i = 1'b1;
      tick();
      redir_if.redir_ready_i = 1'b0;
      chk($sformatf("v%0d_hs_drop", i), {31'd0, redir_if.redir_valid_o}, 32'd0);
      drain($sformatf("v%0d", i), FC, pulses);
    end
    tick();
    chk($sformatf("v%0d_one_pulse", i), {31'd0, resolve_valid_o}, 32'd0);
    chk_perf($sformatf("v%0d", i));
  endtask

  // ---------------- test ----------------
  initial begin
    int pulses;
    rst = 1'b1;
    issue_valid_i = 1'b0;
    issue_is_branch_i = 1'b0;
    issue_op_i = 4'd0;
    issue_pc_i = '0;
    issue_imm_i = '0;
    issue_pred_taken_i = 1'b0;
    alu_res_i = '0;
    alu_zero_i = 1'b0;
    redir_if.redir_ready_i = 1'b0;

    //                op       pc             imm            pred  res    zero  tk    mp    exp_pc
    vecs[0] = '{4'b1010, 32'h0000_0100, 32'h0000_0020, 1'b1, 32'd0, 1'b1, 1'b1, 1'b0, 32'h0000_0120};
    vecs[1] = '{4'b1010, 32'h0000_0100, 32'h0000_0020, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0104};
    vecs[2] = '{4'b1011, 32'h0000_0200, 32'h0000_0040, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h0000_0240};
    vecs[3] = '{4'b1100, 32'h0000_0300, 32'hFFFF_FFF0, 1'b1, 32'd1, 1'b0, 1'b1, 1'b0, 32'h0000_02F0};
    vecs[4] = '{4'b1110, 32'h0000_0400, 32'h0000_0008, 1'b1, 32'd0, 1'b1, 1'b0, 1'b1, 32'h0000_0404};
    vecs[5] = '{4'b1101, 32'h0000_0500, 32'h0000_0010, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h0000_0510};
    vecs[6] = '{4'b1111, 32'hFFFF_FFFC, 32'h0000_0100, 1'b1, 32'd1, 1'b0, 1'b0, 1'b1, 32'h0000_0000};
    vecs[7] = '{4'b1111, 32'hFFFF_FFF0, 32'h0000_0020, 1'b1, 32'd0, 1'b0, 1'b1, 1'b0, 32'h0000_0010};
    vecs[8] = '{4'b0000, 32'h0000_0600, 32'h0000_0008, 1'b1, 32'd1, 1'b1, 1'b0, 1'b0, 32'h0000_0604};
    vecs[9] = '{4'b1011, 32'h0000_0700, 32'h0000_0004, 1'b1, 32'd0, 1'b0, 1'b1, 1'b0, 32'h0000_0704};

    // Reset state
    tick();
    chk("rst_stall",   {31'd0, stall_o}, 32'd0);
    chk("rst_flush",   {31'd0, flush_o}, 32'd0);
    chk("rst_redir_v", {31'd0, redir_if.redir_valid_o}, 32'd0);
    chk("rst_redir_pc", redir_if.redir_pc_o, 32'd0);
    chk("rst_rvalid",  {31'd0, resolve_valid_o}, 32'd0);
    chk("rst_rpc",     resolve_pc_o, 32'd0);
    chk("rst_state",   {30'd0, dbg_state_o}, 32'd0);
    chk_perf("rst");
    rst = 1'b0;
    tick();

    // Table-driven single branches
    for (int i = 0; i < 10; i++) run_vec(i);

    // Mispredict with ready held low; ready before REDIRECT and stalled issues are ignored
    redir_if.redir_ready_i = 1'b1;
    drive_issue(4'b1011, 32'h0000_0200, 32'h0000_0040, 1'b0);
    tick();
    issue_valid_i = 1'b0;
    alu_zero_i    = 1'b0;
    tick();
    redir_if.redir_ready_i = 1'b0;
    chk("hold_rvalid",   {31'd0, resolve_valid_o}, 32'd1);
    chk("hold_redir_v0", {31'd0, redir_if.redir_valid_o}, 32'd1);
    chk("hold_redir_pc0", redir_if.redir_pc_o, 32'h0000_0240);
    model_br++;
    model_mp++;
    drive_issue(4'b1010, 32'h0000_0B00, 32'h0000_0010, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("hold%0d_redir_v", k), {31'd0, redir_if.redir_valid_o}, 32'd1);
      chk($sformatf("hold%0d_redir_pc", k), redir_if.redir_pc_o, 32'h0000_0240);
      chk($sformatf("hold%0d_stall", k), {31'd0, stall_o}, 32'd1);
      chk($sformatf("hold%0d_flush", k), {31'd0, flush_o}, 32'd1);
      chk($sformatf("hold%0d_rvalid", k), {31'd0, resolve_valid_o}, 32'd0);
    end
    issue_valid_i = 1'b0;
    redir_if.redir_ready_i = 1'b1;
    tick();
    redir_if.redir_ready_i = 1'b0;
    chk("hold_hs_redir_v", {31'd0, redir_if.redir_valid_o}, 32'd0);
    chk("hold_hs_flush",   {31'd0, flush_o}, 32'd1);
    tick();
    chk("hold_f2_flush", {31'd0, flush_o}, 32'd1);
    chk("hold_f2_stall", {31'd0, stall_o}, 32'd1);
    tick();
    chk("hold_idle_flush", {31'd0, flush_o}, 32'd0);
    chk("hold_idle_stall", {31'd0, stall_o}, 32'd0);
    chk("hold_no_ghost0", {31'd0, resolve_valid_o}, 32'd0);
    tick();
    chk("hold_no_ghost1", {31'd0, resolve_valid_o}, 32'd0);
    chk_perf("hold");

    // Wrong-path squash
    do_reset();
    drive_issue(4'b1010, 32'h0000_0800, 32'h0000_0010, 1'b0);
    tick();
    drive_issue(4'b1010, 32'h0000_0900, 32'h0000_0010, 1'b0);
    alu_zero_i = 1'b1;
    tick();
    issue_valid_i = 1'b0;
    alu_zero_i    = 1'b0;
    chk("sq_a_rvalid",  {31'd0, resolve_valid_o}, 32'd1);
    chk("sq_a_rpc",     resolve_pc_o, 32'h0000_0800);
    chk("sq_a_redir_pc", redir_if.redir_pc_o, 32'h0000_0810);
    model_br++;
    model_mp++;
    tick();
    chk("sq_b_dropped", {31'd0, resolve_valid_o}, 32'd0);
    redir_if.redir_ready_i = 1'b1;
    tick();
    redir_if.redir_ready_i = 1'b0;
    drain("sq", FC, pulses);
    chk("sq_no_pulse", 32'(pulses), 32'd0);
    tick();
    chk("sq_no_pulse_late", {31'd0, resolve_valid_o}, 32'd0);
    chk_perf("sq");

    // Back-to-back correctly predicted BLT
    alu_res_i = 32'd1;
    for (int c = 0; c < 7; c++) begin
      if (c < 4) begin
        drive_issue(4'b1100, 32'h0000_0A00 + 32'(16 * c), 32'h0000_0008, 1'b1);
        exp_q.push_back(32'h0000_0A00 + 32'(16 * c));
      end else begin
        issue_valid_i = 1'b0;
      end
      tick();
      chk($sformatf("b2b%0d_stall", c), {31'd0, stall_o}, 32'd0);
      if (c + 1 >= 2 && c + 1 <= 5) begin
        logic [DW-1:0] exp_pc;
        if (exp_q.size() > 0) exp_pc = exp_q.pop_front();
        else exp_pc = '1;
        chk($sformatf("b2b%0d_rvalid", c), {31'd0, resolve_valid_o}, 32'd1);
        chk($sformatf("b2b%0d_rpc", c), resolve_pc_o, exp_pc);
        chk($sformatf("b2b%0d_tgt", c), redir_if.redir_pc_o, exp_pc + 32'd8);
        model_br++;
      end else begin
        chk($sformatf("b2b%0d_rvalid", c), {31'd0, resolve_valid_o}, 32'd0);
      end
    end
    chk("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
    chk_perf("b2b");

    // Reset in the middle of REDIRECT
    drive_issue(4'b1100, 32'h0000_0C00, 32'h0000_0008, 1'b0);
    tick();
    issue_valid_i = 1'b0;
    alu_res_i = 32'd1;
    tick();
    chk("mr_redir_v", {31'd0, redir_if.redir_valid_o}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_br = 0;
    model_mp = 0;
    chk("mr_redir_v0", {31'd0, redir_if.redir_valid_o}, 32'd0);
    chk("mr_flush",    {31'd0, flush_o}, 32'd0);
    chk("mr_stall",    {31'd0, stall_o}, 32'd0);
    chk("mr_rvalid",   {31'd0, resolve_valid_o}, 32'd0);
    chk_perf("mr");
    tick();
    chk("mr_stays_idle", {31'd0, stall_o}, 32'd0);
    run_vec(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
